operand_fetch_unit: RTL
=======================

Name: operand_fetch_unit

Overview:
- ID-stage initiator for the two-read/one-write MIPS register file.
- Drives the register file read addresses and captures the returned data.
- Applies EX/MEM/WB bypassing, detects load-use hazards and inserts bubbles.
- Registers operands into the ID/EX boundary under a valid/ready handshake.

Parameters:
DATA_WIDTH, 32, operand/data width
ADDR_WIDTH, 5, register index width (32 registers)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low (0 = reset asserted)
id_valid  in  1  decoded instruction present in ID
id_rs  in  ADDR_WIDTH  source register 1 index
id_rt  in  ADDR_WIDTH  source register 2 index
id_use_rs  in  1  instruction reads rs
id_use_rt  in  1  instruction reads rt
id_stall  out  1  ID must hold its instruction this cycle
rf_raddr1  out  ADDR_WIDTH  register file read address 1 (= id_rs)
rf_raddr2  out  ADDR_WIDTH  register file read address 2 (= id_rt)
rf_rdata1  in  DATA_WIDTH  register file read data 1 (combinational)
rf_rdata2  in  DATA_WIDTH  register file read data 2 (combinational)
ex_fwd_en, ex_fwd_load, ex_fwd_addr, ex_fwd_data  in  1,1,ADDR_WIDTH,DATA_WIDTH  EX-stage pending write; ex_fwd_load marks a load, data not yet valid
mem_fwd_en, mem_fwd_addr, mem_fwd_data  in  1,ADDR_WIDTH,DATA_WIDTH  MEM-stage pending write, data valid (load data included)
wb_fwd_en, wb_fwd_addr, wb_fwd_data  in  1,ADDR_WIDTH,DATA_WIDTH  WB write being committed this edge
ex_ready  in  1  EX accepts the ID/EX register this cycle
ex_valid  out  1  ID/EX register holds an instruction
ex_op_a  out  DATA_WIDTH  resolved rs operand
ex_op_b  out  DATA_WIDTH  resolved rt operand
ex_rs, ex_rt  out  ADDR_WIDTH  registered source indices

Behaviour:
- Reset (reset=0, asynchronous): ex_valid=0, ex_op_a=ex_op_b=0, ex_rs=ex_rt=0, state=RUN. id_stall goes low combinationally. Reset asserted mid-stall abandons the stall; the first post-reset cycle is RUN.
- Read addresses are pure pass-through: rf_raddr1=id_rs, rf_raddr2=id_rt.
- Operand resolution per source (src, used):
  - index 0 -> 0, regardless of any forwarding source.
  - Otherwise, highest priority first: EX match (ex_fwd_en, addr equal, not load) -> ex_fwd_data; MEM match -> mem_fwd_data; WB match -> wb_fwd_data (the register file write lands at the same edge); else rf_rdata.
  - Unused sources resolve normally but cannot cause a hazard.
- Load-use hazard: id_valid & used src≠0 & ex_fwd_en & ex_fwd_load & ex_fwd_addr==src.
- States:
  - RUN: if hazard -> id_stall=1, load bubble (ex_valid=0), go to LU_STALL. Else if ex_ready or !ex_valid -> load ID/EX with id_valid and resolved operands.
  - LU_STALL: exactly one cycle. The load is now in MEM and is forwarded from mem_fwd_data. id_stall=0, load the instruction, return to RUN. If ex_ready=0 here, remain in LU_STALL with id_stall=1.
  - HOLD (ex_valid & !ex_ready): ID/EX register frozen, id_stall=1. The whole pipeline is frozen too, so forwarding inputs are stable. Return to RUN when ex_ready=1.
- Latency: one cycle from ID to ex_*; two cycles on a load-use hazard.
- Bubble: ex_valid=0; ex_op_a/ex_op_b keep their old values (don't-care).
- id_valid=0 with ex_ready=1: ex_valid goes 0, no stall.

Optional Feature:
OPERAND_FETCH_STATS_EN
- Defined: adds output stall_count [31:0], reset to 0. Increments by 1 on every clock with id_valid & id_stall. Saturates at 32'hFFFFFFFF with no wrap.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset: hold reset=0 with random inputs -> ex_valid=0, ex_op_a=0, id_stall=0. Release; issue rs=3 with rf_rdata1=32'h1234 -> next cycle ex_op_a=32'h1234, ex_valid=1.
- Priority: rs=5 matched by EX (32'hA), MEM (32'hB) and WB (32'hC) -> ex_op_a=32'hA. Drop EX -> 32'hB. Drop MEM -> 32'hC.
- r0: rs=0, all forward sources target addr 0 with 32'hFFFF -> ex_op_a=0, no stall.
- Load-use: EX load to r7, ID uses rt=7 -> id_stall=1 for 1 cycle, bubble. Next cycle mem_fwd_data=32'h55 -> ex_op_b=32'h55. Same case with id_use_rt=0 -> no stall.
- Backpressure: ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* unchanged, id_stall=1 throughout. With STATS_EN defined, stall_count increases by 3.
- Async reset asserted during LU_STALL -> outputs cleared immediately. After release, no residual stall.

Source files
------------

// File: rtl/operand_fetch_unit_if.sv
// ID/EX boundary handshake: valid/ready plus the registered operands.
// master = operand_fetch_unit (drives ex_*), slave = EX stage (drives ex_ready).
interface operand_fetch_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) ();
  logic                  ex_valid;
  logic                  ex_ready;
  logic [DATA_WIDTH-1:0] ex_op_a;
  logic [DATA_WIDTH-1:0] ex_op_b;
  logic [ADDR_WIDTH-1:0] ex_rs;
  logic [ADDR_WIDTH-1:0] ex_rt;

  modport master (
    output ex_valid,
    output ex_op_a,
    output ex_op_b,
    output ex_rs,
    output ex_rt,
    input  ex_ready
  );

  modport slave (
    input  ex_valid,
    input  ex_op_a,
    input  ex_op_b,
    input  ex_rs,
    input  ex_rt,
    output ex_ready
  );
endinterface

// File: rtl/operand_fetch_unit.sv
// ID-stage operand fetch: RF read, EX/MEM/WB bypass, load-use bubble, ID/EX reg.
// Ports: clk, reset (async, active-low), id_* decode inputs, id_stall,
//   rf_raddr*/rf_rdata* register file bus, ex/mem/wb_fwd_* bypass sources,
//   ex (operand_fetch_unit_if.master) ID/EX handshake.
// Optional: define OPERAND_FETCH_STATS_EN to add the stall_count[31:0] output.
module operand_fetch_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [ADDR_WIDTH-1:0] id_rs,
  input  logic [ADDR_WIDTH-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  output logic                  id_stall,
  output logic [ADDR_WIDTH-1:0] rf_raddr1,
  output logic [ADDR_WIDTH-1:0] rf_raddr2,
  input  logic [DATA_WIDTH-1:0] rf_rdata1,
  input  logic [DATA_WIDTH-1:0] rf_rdata2,
  input  logic                  ex_fwd_en,
  input  logic                  ex_fwd_load,
  input  logic [ADDR_WIDTH-1:0] ex_fwd_addr,
  input  logic [DATA_WIDTH-1:0] ex_fwd_data,
  input  logic                  mem_fwd_en,
  input  logic [ADDR_WIDTH-1:0] mem_fwd_addr,
  input  logic [DATA_WIDTH-1:0] mem_fwd_data,
  input  logic                  wb_fwd_en,
  input  logic [ADDR_WIDTH-1:0] wb_fwd_addr,
  input  logic [DATA_WIDTH-1:0] wb_fwd_data,
  operand_fetch_unit_if.master  ex
`ifdef OPERAND_FETCH_STATS_EN
  ,
  output logic [31:0]           stall_count
`endif
);

  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_op_a;
  logic [DATA_WIDTH-1:0] r_op_b;
  logic [ADDR_WIDTH-1:0] r_rs;
  logic [ADDR_WIDTH-1:0] r_rt;

  logic                  w_hold;
  logic                  w_hazard;
  logic                  w_stall;
  logic                  w_load;
  logic                  w_bubble;
  logic [DATA_WIDTH-1:0] w_op_a;
  logic [DATA_WIDTH-1:0] w_op_b;

  assign rf_raddr1 = id_rs;
  assign rf_raddr2 = id_rt;

  // Youngest producer wins; a load in EX has no data yet so it is skipped.
  function automatic logic [DATA_WIDTH-1:0] f_resolve(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] rf,
    input logic                  exe,
    input logic                  exl,
    input logic [ADDR_WIDTH-1:0] exa,
    input logic [DATA_WIDTH-1:0] exd,
    input logic                  me,
    input logic [ADDR_WIDTH-1:0] ma,
    input logic [DATA_WIDTH-1:0] md,
    input logic                  we,
    input logic [ADDR_WIDTH-1:0] wa,
    input logic [DATA_WIDTH-1:0] wd
  );
    logic [DATA_WIDTH-1:0] v;
    if (a == '0)                        v = '0;
    else if (exe && !exl && exa == a)   v = exd;
    else if (me && ma == a)             v = md;
    else if (we && wa == a)             v = wd;
    else                                v = rf;
    return v;
  endfunction

  always_comb begin
    w_op_a = f_resolve(id_rs, rf_rdata1,
                       ex_fwd_en, ex_fwd_load, ex_fwd_addr, ex_fwd_data,
                       mem_fwd_en, mem_fwd_addr, mem_fwd_data,
                       wb_fwd_en, wb_fwd_addr, wb_fwd_data);
    w_op_b = f_resolve(id_rt, rf_rdata2,
                       ex_fwd_en, ex_fwd_load, ex_fwd_addr, ex_fwd_data,
                       mem_fwd_en, mem_fwd_addr, mem_fwd_data,
                       wb_fwd_en, wb_fwd_addr, wb_fwd_data);
  end

  always_comb begin
    w_hazard = 1'b0;
    if (id_valid && ex_fwd_en && ex_fwd_load) begin
      if (id_use_rs && id_rs != '0 && ex_fwd_addr == id_rs)
        w_hazard = 1'b1;
      if (id_use_rt && id_rt != '0 && ex_fwd_addr == id_rt)
        w_hazard = 1'b1;
    end
  end

  assign w_hold = r_valid & ~ex.ex_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= RUN;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      RUN:      if (!w_hold && w_hazard) w_next = LU_STALL;
      LU_STALL: if (ex.ex_ready)         w_next = RUN;
      default:  w_next = RUN;
    endcase
  end

  // An occupied, unaccepted ID/EX register outranks a hazard bubble.
  always_comb begin
    w_stall  = 1'b0;
    w_load   = 1'b0;
    w_bubble = 1'b0;
    unique case (r_state)
      RUN: begin
        if (w_hold) begin
          w_stall = 1'b1;
        end else if (w_hazard) begin
          w_stall  = 1'b1;
          w_bubble = 1'b1;
        end else begin
          w_load = 1'b1;
        end
      end
      LU_STALL: begin
        if (ex.ex_ready) w_load  = 1'b1;
        else             w_stall = 1'b1;
      end
      default: ;
    endcase
  end

  // Gated so the stall drops the moment reset asserts.
  assign id_stall = reset & w_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_rs    <= '0;
      r_rt    <= '0;
    end else if (w_load) begin
      r_valid <= id_valid;
      if (id_valid) begin
        r_op_a <= w_op_a;
        r_op_b <= w_op_b;
        r_rs   <= id_rs;
        r_rt   <= id_rt;
      end
    end else if (w_bubble) begin
      r_valid <= 1'b0;
    end
  end

  assign ex.ex_valid = r_valid;
  assign ex.ex_op_a  = r_op_a;
  assign ex.ex_op_b  = r_op_b;
  assign ex.ex_rs    = r_rs;
  assign ex.ex_rt    = r_rt;

`ifdef OPERAND_FETCH_STATS_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_stall_cnt <= '0;
    else if (id_valid && id_stall && r_stall_cnt != 32'hFFFF_FFFF)
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_count = r_stall_cnt;
`endif

endmodule
